decode_mul_arb: RTL and testbench

DECODE_MUL_ARB -- requirements
Module: decode_mul_arb

---
 rtl/decode_mul_arb_pkg.sv | 15 +
 rtl/decode_mul_core.sv | 37 +++
 rtl/decode_mul_arb.sv | 110 +++++++++++
 tb/tb_decode_mul_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_mul_arb_pkg.sv
// Shared defaults and helpers for the round-robin arbitrated multiplier.
package decode_mul_arb_pkg;

  localparam int unsigned DefNumReq     = 4;
  localparam int unsigned DefAWidth     = 40;
  localparam int unsigned DefBWidth     = 20;
  localparam int unsigned DefPWidth     = 59;
  localparam int unsigned DefMulLatency = 2;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decode_mul_core.sv
// Signed pipelined multiplier; full product truncated to P_WIDTH, LATENCY registered stages.
module decode_mul_core
  import decode_mul_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH = DefAWidth,
  parameter int unsigned B_WIDTH = DefBWidth,
  parameter int unsigned P_WIDTH = DefPWidth,
  parameter int unsigned LATENCY = DefMulLatency
) (
  input  logic                      clk,
  input  logic                      ce,
  input  logic                      reset,
  input  logic signed [A_WIDTH-1:0] din0,
  input  logic signed [B_WIDTH-1:0] din1,
  output logic signed [P_WIDTH-1:0] dout
);

  localparam int unsigned FullW = A_WIDTH + B_WIDTH;

  logic [FullW-1:0]   full;
  logic [P_WIDTH-1:0] p_q [LATENCY];

  // Sign-extend both operands to full width; the low FullW bits of the product are exact.
  assign full = {{B_WIDTH{din0[A_WIDTH-1]}}, din0} * {{A_WIDTH{din1[B_WIDTH-1]}}, din1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) p_q[i] <= '0;
    end else if (ce) begin
      p_q[0] <= full[P_WIDTH-1:0];
      for (int i = 1; i < int'(LATENCY); i++) p_q[i] <= p_q[i-1];
    end
  end

  assign dout = p_q[LATENCY-1];

endmodule

// File: rtl/decode_mul_arb.sv
// Round-robin arbiter feeding one shared pipelined signed multiplier with in-order results.
module decode_mul_arb
  import decode_mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned A_WIDTH     = DefAWidth,
  parameter int unsigned B_WIDTH     = DefBWidth,
  parameter int unsigned P_WIDTH     = DefPWidth,
  parameter int unsigned MUL_LATENCY = DefMulLatency
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]        req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]        req_b,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic signed [P_WIDTH-1:0]         res_data,
  output logic [id_width(NUM_REQ)-1:0]      res_id,
  output logic                              busy
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  logic                      stall;
  logic                      ce;
  logic                      xfer;
  logic                      found;
  logic [NUM_REQ-1:0]        grant;
  logic [IdW-1:0]            gnt_id;
  logic [IdW-1:0]            idx;
  logic [IdW-1:0]            last_q;

  logic                      iss_v_q;
  logic [IdW-1:0]            iss_id_q;
  logic signed [A_WIDTH-1:0] a_q;
  logic signed [B_WIDTH-1:0] b_q;
  logic [MUL_LATENCY-1:0]    v_q;
  logic [IdW-1:0]            id_q [MUL_LATENCY];

  assign stall = res_valid & ~res_ready;
  assign ce    = ~stall;

  // Search upward from the requester after the last grant; nothing granted while stalled.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    if (!stall) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = IdW'((32'(last_q) + k) % NUM_REQ);
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          grant[idx]  = 1'b1;
          gnt_id      = idx;
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= IdW'(NUM_REQ - 1);
      iss_v_q <= 1'b0;
      v_q     <= '0;
    end else begin
      if (xfer) last_q <= gnt_id;
      if (ce) begin
        iss_v_q <= xfer;
        v_q[0]  <= iss_v_q;
        for (int i = 1; i < int'(MUL_LATENCY); i++) v_q[i] <= v_q[i-1];
      end
    end
  end

  // Operand capture and id tracking carry no reset; validity lives in the bits above.
  always_ff @(posedge clk) begin
    if (ce) begin
      iss_id_q <= gnt_id;
      a_q      <= req_a[gnt_id*A_WIDTH +: A_WIDTH];
      b_q      <= req_b[gnt_id*B_WIDTH +: B_WIDTH];
      id_q[0]  <= iss_id_q;
      for (int i = 1; i < int'(MUL_LATENCY); i++) id_q[i] <= id_q[i-1];
    end
  end

  decode_mul_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH),
    .LATENCY (MUL_LATENCY)
  ) u_core (
    .clk   (clk),
    .ce    (ce),
    .reset (reset),
    .din0  (a_q),
    .din1  (b_q),
    .dout  (res_data)
  );

  assign res_valid = v_q[MUL_LATENCY-1];
  assign res_id    = id_q[MUL_LATENCY-1];
  assign busy      = iss_v_q | (|v_q);

endmodule

// File: tb/tb_decode_mul_arb.sv
// Scoreboard bench: driver pushes expected results per grant, monitor pops on each accepted result.
module tb_decode_mul_arb;

  localparam int N  = 4;
  localparam int AW = 40;
  localparam int BW = 20;
  localparam int PW = 59;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [PW-1:0]   res_data;
  logic [1:0]      res_id;
  logic            busy;

  typedef struct {
    logic [1:0]    id;
    logic [PW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t                  sb[$];
  int                    errors = 0;
  int                    checks = 0;
  int                    cyc = 0;
  logic signed [AW-1:0]  a_v [N];
  logic signed [BW-1:0]  b_v [N];
  logic                  hand_en = 1'b0;
  logic [PW-1:0]         hand_val;
  logic                  lat_en = 1'b0;

  decode_mul_arb #(
    .NUM_REQ     (N),
    .A_WIDTH     (AW),
    .B_WIDTH     (BW),
    .P_WIDTH     (PW),
    .MUL_LATENCY (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic signed [AW-1:0] a,
                                          input logic signed [BW-1:0] b);
    logic signed [AW+BW-1:0] f;
    f = a * b;
    return f[PW-1:0];
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_v[i];
      req_b[i*BW +: BW] = b_v[i];
    end
  endtask

  // One cycle: check the expected grant, and on a transfer queue its expected result.
  task automatic step(input logic [N-1:0] exp_rdy);
    int gid;
    exp_t e;
    gid = 0;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if ((req_valid & exp_rdy) != '0) begin
      for (int i = 0; i < N; i++) if (exp_rdy[i]) gid = i;
      e.id   = 2'(gid);
      e.data = hand_en ? hand_val : model(a_v[gid], b_v[gid]);
      e.cyc  = lat_en ? cyc + L : -1;
      sb.push_back(e);
      hand_en  = 1'b0;
      a_v[gid] = a_v[gid] + 40'sd1013;
      b_v[gid] = -b_v[gid] + 20'sd3;
      apply();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    chk("idle_res_valid", 64'(res_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result must match the queue head; pop when accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got res_valid=1 id=%0d, expected no result", res_id);
        end else begin
          chk("res_id", 64'(res_id), 64'(sb[0].id));
          chk("res_data", 64'(res_data), 64'(sb[0].data));
          if (sb[0].cyc >= 0) chk("latency", 64'(cyc), 64'(sb[0].cyc));
          if (res_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    apply();
    #1;
    do_reset();
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // Single request from requester 0.
    a_v[0] = -40'sd3;
    b_v[0] = 20'sd7;
    apply();
    req_valid = 4'b0001;
    hand_en   = 1'b1;
    hand_val  = -59'sd21;
    lat_en    = 1'b1;
    step(4'b0001);
    req_valid = '0;
    drain();

    // Streaming from reset: grants 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 40'(-(i + 1) * 123457);
      b_v[i] = 20'((i + 3) * 311 * ((i % 2 == 1) ? -1 : 1));
    end
    apply();
    req_valid = 4'b1111;
    lat_en    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) lat_en = 1'b0;
      step(4'(1 << (k % 4)));
    end

    // Backpressure with a full pipeline, then release with continued rotation.
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(4'b0000);
      if (k == 0) chk("busy_stall", 64'(busy), 64'd1);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) step(4'(1 << k));
    req_valid = '0;
    drain();

    // Operand extremes on requester 0 (last grant was 3).
    a_v[0] = 40'sh80_0000_0000;
    b_v[0] = 20'sh80000;
    apply();
    req_valid = 4'b0001;
    hand_en   = 1'b1;
    hand_val  = 59'h400_0000_0000_0000;
    lat_en    = 1'b1;
    step(4'b0001);
    a_v[0] = 40'sh7F_FFFF_FFFF;
    b_v[0] = 20'sh7FFFF;
    apply();
    hand_en  = 1'b1;
    hand_val = 59'h3FF_FF7F_FFFF_FFFF & model(a_v[0], b_v[0]);
    hand_val = model(a_v[0], b_v[0]);
    step(4'b0001);
    req_valid = '0;
    drain();

    // Requesters 1 and 3 with last grant 1: grant 3 then 1.
    req_valid = 4'b0010;
    step(4'b0010);
    req_valid = 4'b1010;
    step(4'b1000);
    step(4'b0010);
    req_valid = '0;
    drain();

    // Reset with two operations in flight.
    req_valid = 4'b1100;
    step(4'b0100);
    step(4'b1000);
    req_valid = '0;
    do_reset();
    for (int k = 0; k < 5; k++) step(4'b0000);
    req_valid = 4'b1111;
    step(4'b0001);
    req_valid = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
